// File: rtl/reorder_buffer_p_pkg.sv
// ============================================================================
// Module   : reorder_buffer_p_pkg
// Purpose  : Shared configuration for the reorder buffer: default depth,
//            tag-width helper, branch-direction encoding, entry-class flags.
// Revision : 1.0
// ============================================================================
`default_nettype none

package reorder_buffer_p_pkg;

    localparam int c_ROB_DEPTH_DEF = 32;

    // Branch direction encoding shared by predictor and EX
    localparam logic c_NOT_JUMP = 1'b0;
    localparam logic c_JUMP     = 1'b1;

    typedef struct packed {
        logic is_store;
        logic is_branch;
        logic pred;
    } rob_class_t;

    function automatic int rob_tag_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

`default_nettype wire

// File: rtl/reorder_buffer_p_if.sv
// ============================================================================
// Module   : reorder_buffer_p_if
// Purpose  : Dispatch / writeback / commit bundle of the reorder buffer.
//            Query ports exist only when ROB_FWD_EN is defined.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface reorder_buffer_p_if
    import reorder_buffer_p_pkg::*;
#(
    parameter int DEPTH  = c_ROB_DEPTH_DEF,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
);
    localparam int TAG_W = rob_tag_w(DEPTH);

    logic              alloc_valid_i;
    logic              alloc_ready_o;
    logic [TAG_W-1:0]  alloc_tag_o;
    logic [REG_W-1:0]  alloc_rd_i;
    logic              alloc_is_store_i;
    logic              alloc_is_branch_i;
    logic              alloc_pred_taken_i;

    logic              ex_valid_i;
    logic [TAG_W-1:0]  ex_tag_i;
    logic [DATA_W-1:0] ex_data_i;
    logic              ex_taken_i;
    logic [ADDR_W-1:0] ex_npc_i;

    logic              lsb_valid_i;
    logic [TAG_W-1:0]  lsb_tag_i;
    logic [DATA_W-1:0] lsb_data_i;

    logic              st_commit_valid_o;
    logic [TAG_W-1:0]  st_commit_tag_o;
    logic              st_commit_ack_i;

    logic              rf_we_o;
    logic [REG_W-1:0]  rf_rd_o;
    logic [DATA_W-1:0] rf_data_o;
    logic [TAG_W-1:0]  rf_tag_o;

    logic              flush_o;
    logic [ADDR_W-1:0] flush_pc_o;
    logic [TAG_W:0]    count_o;

`ifdef ROB_FWD_EN
    logic [TAG_W-1:0]  q0_tag_i;
    logic              q0_ready_o;
    logic [DATA_W-1:0] q0_data_o;
    logic [TAG_W-1:0]  q1_tag_i;
    logic              q1_ready_o;
    logic [DATA_W-1:0] q1_data_o;
`endif

    modport master (
        output alloc_valid_i, alloc_rd_i, alloc_is_store_i, alloc_is_branch_i,
               alloc_pred_taken_i,
               ex_valid_i, ex_tag_i, ex_data_i, ex_taken_i, ex_npc_i,
               lsb_valid_i, lsb_tag_i, lsb_data_i, st_commit_ack_i,
        input  alloc_ready_o, alloc_tag_o, st_commit_valid_o, st_commit_tag_o,
               rf_we_o, rf_rd_o, rf_data_o, rf_tag_o, flush_o, flush_pc_o, count_o
`ifdef ROB_FWD_EN
        ,
        output q0_tag_i, q1_tag_i,
        input  q0_ready_o, q0_data_o, q1_ready_o, q1_data_o
`endif
    );

    modport slave (
        input  alloc_valid_i, alloc_rd_i, alloc_is_store_i, alloc_is_branch_i,
               alloc_pred_taken_i,
               ex_valid_i, ex_tag_i, ex_data_i, ex_taken_i, ex_npc_i,
               lsb_valid_i, lsb_tag_i, lsb_data_i, st_commit_ack_i,
        output alloc_ready_o, alloc_tag_o, st_commit_valid_o, st_commit_tag_o,
               rf_we_o, rf_rd_o, rf_data_o, rf_tag_o, flush_o, flush_pc_o, count_o
`ifdef ROB_FWD_EN
        ,
        input  q0_tag_i, q1_tag_i,
        output q0_ready_o, q0_data_o, q1_ready_o, q1_data_o
`endif
    );

endinterface

`default_nettype wire

// File: rtl/reorder_buffer_p_qport.sv
// ============================================================================
// Module   : reorder_buffer_p_qport
// Purpose  : Single operand-forwarding lookup by tag with same-cycle
//            writeback bypass (EX wins over LSB). Built only with ROB_FWD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifdef ROB_FWD_EN
module reorder_buffer_p_qport
    import reorder_buffer_p_pkg::*;
#(
    parameter  int DEPTH  = c_ROB_DEPTH_DEF,
    parameter  int DATA_W = 32,
    localparam int TAG_W  = rob_tag_w(DEPTH)
) (
    input  logic [TAG_W-1:0]  i_tag,
    input  logic [DEPTH-1:0]  i_busy,
    input  logic [DEPTH-1:0]  i_done,
    input  logic [DATA_W-1:0] i_data [DEPTH],
    input  logic              i_ex_wb,
    input  logic [TAG_W-1:0]  i_ex_tag,
    input  logic [DATA_W-1:0] i_ex_data,
    input  logic              i_lsb_wb,
    input  logic [TAG_W-1:0]  i_lsb_tag,
    input  logic [DATA_W-1:0] i_lsb_data,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data
);

    // Writeback strobes arrive already qualified by busy/rdy; EX is applied last so it wins.
    always_comb begin
        o_ready = i_busy[i_tag] && i_done[i_tag];
        o_data  = i_data[i_tag];
        if (i_lsb_wb && (i_lsb_tag == i_tag)) begin
            o_ready = 1'b1;
            o_data  = i_lsb_data;
        end
        if (i_ex_wb && (i_ex_tag == i_tag)) begin
            o_ready = 1'b1;
            o_data  = i_ex_data;
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/reorder_buffer_p.sv
// ============================================================================
// Module   : reorder_buffer_p
// Purpose  : In-order retirement queue: allocate at tail, EX/LSB writeback,
//            commit at head with store handshake and mispredict flush.
//            Optional forwarding query ports: define ROB_FWD_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module reorder_buffer_p
    import reorder_buffer_p_pkg::*;
#(
    parameter int DEPTH  = c_ROB_DEPTH_DEF,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rdy,
    reorder_buffer_p_if.slave bus
);

    localparam int             TAG_W  = rob_tag_w(DEPTH);
    localparam logic [TAG_W:0] c_FULL = (TAG_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_busy;
    logic [DEPTH-1:0]  r_done;
    logic [DEPTH-1:0]  r_taken;
    rob_class_t        r_cls  [DEPTH];
    logic [REG_W-1:0]  r_rd   [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];
    logic [ADDR_W-1:0] r_npc  [DEPTH];

    logic [TAG_W-1:0]  r_head;
    logic [TAG_W-1:0]  r_tail;
    logic [TAG_W:0]    r_count;

    logic              r_rf_we;
    logic [REG_W-1:0]  r_rf_rd;
    logic [DATA_W-1:0] r_rf_data;
    logic [TAG_W-1:0]  r_rf_tag;
    logic              r_flush;
    logic [ADDR_W-1:0] r_flush_pc;

    logic       w_full;
    logic       w_empty;
    logic       w_alloc_ready;
    rob_class_t w_head_cls;
    logic       w_head_ok;
    logic       w_st_valid;
    logic       w_retire;
    logic       w_mispred;
    logic       w_alloc;
    logic       w_ex_wb;
    logic       w_lsb_wb;

    assign w_full        = (r_count == c_FULL);
    assign w_empty       = (r_count == '0);
    // Gated by rst_n so the port reads 0 while reset is asserted.
    assign w_alloc_ready = rst_n && !w_full && !r_flush;

    assign w_head_cls = r_cls[r_head];
    assign w_head_ok  = !w_empty && r_busy[r_head] && r_done[r_head];
    assign w_st_valid = w_head_ok && w_head_cls.is_store;
    assign w_retire   = rdy && w_head_ok && (!w_head_cls.is_store || bus.st_commit_ack_i);
    assign w_mispred  = w_retire && w_head_cls.is_branch
                        && (r_taken[r_head] != w_head_cls.pred);

    // A mispredicting commit squashes everything else arriving that cycle.
    assign w_alloc  = rdy && bus.alloc_valid_i && w_alloc_ready && !w_mispred;
    assign w_ex_wb  = rdy && bus.ex_valid_i  && r_busy[bus.ex_tag_i]  && !w_mispred;
    assign w_lsb_wb = rdy && bus.lsb_valid_i && r_busy[bus.lsb_tag_i] && !w_mispred;

    // Control state and registered commit outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_done     <= '0;
            r_taken    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_rf_we    <= 1'b0;
            r_rf_rd    <= '0;
            r_rf_data  <= '0;
            r_rf_tag   <= '0;
            r_flush    <= 1'b0;
            r_flush_pc <= '0;
        end else if (rdy) begin
            r_rf_we <= w_retire && !w_head_cls.is_store && (r_rd[r_head] != '0);
            r_flush <= w_mispred;
            if (w_retire) begin
                r_rf_rd   <= r_rd[r_head];
                r_rf_data <= r_data[r_head];
                r_rf_tag  <= r_head;
            end
            if (w_mispred) begin
                r_busy     <= '0;
                r_done     <= '0;
                r_head     <= '0;
                r_tail     <= '0;
                r_count    <= '0;
                r_flush_pc <= r_npc[r_head];
            end else begin
                if (w_ex_wb) begin
                    r_done[bus.ex_tag_i]  <= 1'b1;
                    r_taken[bus.ex_tag_i] <= bus.ex_taken_i;
                end
                if (w_lsb_wb) begin
                    r_done[bus.lsb_tag_i] <= 1'b1;
                end
                if (w_retire) begin
                    r_busy[r_head] <= 1'b0;
                    r_done[r_head] <= 1'b0;
                    r_head         <= r_head + 1'b1;
                end
                if (w_alloc) begin
                    r_busy[r_tail]  <= 1'b1;
                    r_done[r_tail]  <= 1'b0;
                    r_taken[r_tail] <= c_NOT_JUMP;
                    r_tail          <= r_tail + 1'b1;
                end
                r_count <= r_count + (TAG_W+1)'(w_alloc) - (TAG_W+1)'(w_retire);
            end
        end else begin
            r_rf_we <= 1'b0;
            r_flush <= 1'b0;
        end
    end

    // Entry payload needs no reset: busy/done qualify every read.
    always_ff @(posedge clk) begin
        if (w_ex_wb) begin
            r_data[bus.ex_tag_i] <= bus.ex_data_i;
            r_npc[bus.ex_tag_i]  <= bus.ex_npc_i;
        end
        if (w_lsb_wb) begin
            r_data[bus.lsb_tag_i] <= bus.lsb_data_i;
        end
        if (w_alloc) begin
            r_rd[r_tail]  <= bus.alloc_rd_i;
            r_cls[r_tail] <= '{is_store:  bus.alloc_is_store_i,
                               is_branch: bus.alloc_is_branch_i,
                               pred:      bus.alloc_pred_taken_i};
        end
    end

    assign bus.alloc_ready_o     = w_alloc_ready;
    assign bus.alloc_tag_o       = r_tail;
    assign bus.st_commit_valid_o = w_st_valid;
    assign bus.st_commit_tag_o   = r_head;
    assign bus.rf_we_o           = r_rf_we;
    assign bus.rf_rd_o           = r_rf_rd;
    assign bus.rf_data_o         = r_rf_data;
    assign bus.rf_tag_o          = r_rf_tag;
    assign bus.flush_o           = r_flush;
    assign bus.flush_pc_o        = r_flush_pc;
    assign bus.count_o           = r_count;

`ifdef ROB_FWD_EN
    reorder_buffer_p_qport #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_qport0 (
        .i_tag      (bus.q0_tag_i),
        .i_busy     (r_busy),
        .i_done     (r_done),
        .i_data     (r_data),
        .i_ex_wb    (w_ex_wb),
        .i_ex_tag   (bus.ex_tag_i),
        .i_ex_data  (bus.ex_data_i),
        .i_lsb_wb   (w_lsb_wb),
        .i_lsb_tag  (bus.lsb_tag_i),
        .i_lsb_data (bus.lsb_data_i),
        .o_ready    (bus.q0_ready_o),
        .o_data     (bus.q0_data_o)
    );

    reorder_buffer_p_qport #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_qport1 (
        .i_tag      (bus.q1_tag_i),
        .i_busy     (r_busy),
        .i_done     (r_done),
        .i_data     (r_data),
        .i_ex_wb    (w_ex_wb),
        .i_ex_tag   (bus.ex_tag_i),
        .i_ex_data  (bus.ex_data_i),
        .i_lsb_wb   (w_lsb_wb),
        .i_lsb_tag  (bus.lsb_tag_i),
        .i_lsb_data (bus.lsb_data_i),
        .o_ready    (bus.q1_ready_o),
        .o_data     (bus.q1_data_o)
    );
`endif

endmodule

`default_nettype wire

// File: tb/tb_reorder_buffer_p.sv
// ============================================================================
// Module   : tb_reorder_buffer_p
// Purpose  : Scoreboard bench for reorder_buffer_p (DEPTH=32). Register
//            commits and flushes are queued at stimulus time and popped by
//            an independent monitor.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_reorder_buffer_p;
    import reorder_buffer_p_pkg::*;

    localparam int DEPTH  = 32;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int REG_W  = 5;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        logic [4:0]  tag;
    } rf_exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic rdy   = 1'b1;

    int n_chk = 0;
    int n_err = 0;

    rf_exp_t     rfq [$];
    logic [31:0] flq [$];
    rf_exp_t     mon_e;
    logic [4:0]  tl;
    logic [4:0]  tg [32];
    logic [4:0]  ptag;
    logic [4:0]  rdv;

    always #5 clk = ~clk;

    reorder_buffer_p_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) bus ();

    reorder_buffer_p #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .REG_W(REG_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rdy   (rdy),
        .bus   (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_wb();
        bus.ex_valid_i  = 1'b0;
        bus.lsb_valid_i = 1'b0;
    endtask

    task automatic wb_ex(input logic [4:0] tag, input logic [31:0] data,
                         input logic taken, input logic [31:0] npc);
        bus.ex_valid_i = 1'b1;
        bus.ex_tag_i   = tag;
        bus.ex_data_i  = data;
        bus.ex_taken_i = taken;
        bus.ex_npc_i   = npc;
    endtask

    task automatic wb_lsb(input logic [4:0] tag, input logic [31:0] data);
        bus.lsb_valid_i = 1'b1;
        bus.lsb_tag_i   = tag;
        bus.lsb_data_i  = data;
    endtask

    task automatic do_alloc(input logic [4:0] rd, input logic st, input logic br,
                            input logic pr, output logic [4:0] tag);
        bus.alloc_valid_i      = 1'b1;
        bus.alloc_rd_i         = rd;
        bus.alloc_is_store_i   = st;
        bus.alloc_is_branch_i  = br;
        bus.alloc_pred_taken_i = pr;
        chk("alloc_ready", bus.alloc_ready_o, 1);
        chk("alloc_tag", bus.alloc_tag_o, tl);
        tag = tl;
        tl  = tl + 1'b1;
        tick();
        bus.alloc_valid_i = 1'b0;
    endtask

    task automatic wait_count(input logic [5:0] tgt, input int budget, input string name);
        int n = 0;
        while (bus.count_o !== tgt && n < budget) begin
            tick();
            n++;
        end
        chk(name, bus.count_o, tgt);
    endtask

    // Monitor: pops the scoreboard whenever the DUT commits or flushes
    always @(negedge clk) begin
        if (rst_n && bus.rf_we_o) begin
            if (rfq.size() == 0) begin
                chk("rf_unexpected", bus.rf_we_o, 0);
            end else begin
                mon_e = rfq.pop_front();
                chk("rf_rd",   bus.rf_rd_o,   mon_e.rd);
                chk("rf_data", bus.rf_data_o, mon_e.data);
                chk("rf_tag",  bus.rf_tag_o,  mon_e.tag);
            end
        end
        if (rst_n && bus.flush_o) begin
            if (flq.size() == 0) begin
                chk("flush_unexpected", bus.flush_o, 0);
            end else begin
                chk("flush_pc", bus.flush_pc_o, flq.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.alloc_valid_i = 0; bus.alloc_rd_i = 0; bus.alloc_is_store_i = 0;
        bus.alloc_is_branch_i = 0; bus.alloc_pred_taken_i = 0;
        bus.ex_valid_i = 0; bus.ex_tag_i = 0; bus.ex_data_i = 0;
        bus.ex_taken_i = 0; bus.ex_npc_i = 0;
        bus.lsb_valid_i = 0; bus.lsb_tag_i = 0; bus.lsb_data_i = 0;
        bus.st_commit_ack_i = 0;
`ifdef ROB_FWD_EN
        bus.q0_tag_i = 0; bus.q1_tag_i = 0;
`endif
        tl = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alloc_ready", bus.alloc_ready_o, 0);
        chk("rst_count", bus.count_o, 0);
        chk("rst_rf_we", bus.rf_we_o, 0);
        chk("rst_flush", bus.flush_o, 0);
        chk("rst_st_valid", bus.st_commit_valid_o, 0);
        chk("rst_alloc_tag", bus.alloc_tag_o, 0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", bus.alloc_ready_o, 1);

        // Fill all 32 entries, complete in reverse, expect in-order commit
        for (int i = 0; i < 32; i++) begin
            rdv = 5'((i % 31) + 1);
            do_alloc(rdv, 0, 0, 0, tg[i]);
            rfq.push_back('{rd: rdv, data: 32'hA000_0000 + 32'(tg[i]), tag: tg[i]});
        end
        chk("full_count", bus.count_o, 32);
        chk("full_ready", bus.alloc_ready_o, 0);
        for (int k = 0; k < 16; k++) begin
            wb_ex(tg[31-2*k], 32'hA000_0000 + 32'(tg[31-2*k]), 0, 0);
            wb_lsb(tg[30-2*k], 32'hA000_0000 + 32'(tg[30-2*k]));
            tick();
            clr_wb();
        end
        wait_count(0, 80, "drain_full");

        // rd=0 entry retires silently
        do_alloc(5'd0, 0, 0, 0, ptag);
        chk("rd0_count1", bus.count_o, 1);
        wb_ex(ptag, 32'h1234, 0, 0);
        tick();
        clr_wb();
        tick();
        chk("rd0_count0", bus.count_o, 0);
        chk("rd0_no_we", bus.rf_we_o, 0);

        // Mispredicted branch with three younger entries
        do_alloc(5'd3, 0, 1, c_NOT_JUMP, tg[0]);
        for (int i = 1; i < 4; i++) do_alloc(5'd5, 0, 0, 0, tg[i]);
        rfq.push_back('{rd: 5'd3, data: 32'h55, tag: tg[0]});
        flq.push_back(32'h1000);
        wb_lsb(tg[2], 32'h77);
        tick();
        clr_wb();
        wb_ex(tg[0], 32'h55, c_JUMP, 32'h1000);
        tick();
        clr_wb();
        bus.alloc_valid_i = 1'b1;
        bus.alloc_rd_i    = 5'd7;
        tick();
        chk("flush_pulse", bus.flush_o, 1);
        chk("flush_count", bus.count_o, 0);
        chk("flush_ready", bus.alloc_ready_o, 0);
        chk("flush_tail", bus.alloc_tag_o, 0);
        bus.alloc_valid_i = 1'b0;
        tl = 0;
        tick();
        chk("flush_done", bus.flush_o, 0);
        chk("post_flush_ready", bus.alloc_ready_o, 1);

`ifdef ROB_FWD_EN
        // Forwarding query with same-cycle EX bypass
        for (int i = 0; i < 6; i++) do_alloc(5'd0, 0, 0, 0, tg[i]);
        wb_ex(5'd5, 32'hDEAD, 0, 0);
        bus.q0_tag_i = 5'd5;
        bus.q1_tag_i = 5'd4;
        #1;
        chk("q0_ready_byp", bus.q0_ready_o, 1);
        chk("q0_data_byp", bus.q0_data_o, 32'hDEAD);
        chk("q1_not_ready", bus.q1_ready_o, 0);
        tick();
        clr_wb();
        bus.q1_tag_i = 5'd5;
        #1;
        chk("q1_ready_stored", bus.q1_ready_o, 1);
        chk("q1_data_stored", bus.q1_data_o, 32'hDEAD);
        for (int i = 0; i < 5; i++) begin
            wb_ex(tg[i], 32'h0, 0, 0);
            tick();
            clr_wb();
        end
        wait_count(0, 10, "fwd_drain");
`endif

        // Store at head with a delayed ack, younger ALU op behind it
        do_alloc(5'd0, 1, 0, 0, tg[0]);
        do_alloc(5'd4, 0, 0, 0, tg[1]);
        rfq.push_back('{rd: 5'd4, data: 32'h44, tag: tg[1]});
        wb_lsb(tg[0], 32'h5000);
        wb_ex(tg[1], 32'h44, 0, 0);
        tick();
        clr_wb();
        for (int k = 0; k < 3; k++) begin
            chk("st_valid_hold", bus.st_commit_valid_o, 1);
            chk("st_tag", bus.st_commit_tag_o, tg[0]);
            chk("st_count_hold", bus.count_o, 2);
            if (k == 2) bus.st_commit_ack_i = 1'b1;
            tick();
        end
        bus.st_commit_ack_i = 1'b0;
        chk("st_valid_drop", bus.st_commit_valid_o, 0);
        chk("st_retired_count", bus.count_o, 1);
        tick();
        chk("st_next_count", bus.count_o, 0);
        chk("st_next_we", bus.rf_we_o, 1);

        // rdy low freezes retirement
        do_alloc(5'd6, 0, 0, 0, ptag);
        rfq.push_back('{rd: 5'd6, data: 32'h66, tag: ptag});
        wb_ex(ptag, 32'h66, 0, 0);
        tick();
        clr_wb();
        rdy = 1'b0;
        tick();
        tick();
        chk("frz_count", bus.count_o, 1);
        chk("frz_we", bus.rf_we_o, 0);
        rdy = 1'b1;
        tick();
        chk("unfrz_we", bus.rf_we_o, 1);
        chk("unfrz_count", bus.count_o, 0);

        // Streaming alloc+retire each cycle; tail wraps 31 -> 0
        for (int i = 0; i < 34; i++) begin
            if (i > 0) wb_ex(ptag, 32'hB00 + 32'(i - 1), 0, 0);
            rdv = 5'((i % 31) + 1);
            do_alloc(rdv, 0, 0, 0, tg[0]);
            clr_wb();
            rfq.push_back('{rd: rdv, data: 32'hB00 + 32'(i), tag: tg[0]});
            if (i >= 1) chk("stream_count", bus.count_o, 2);
            ptag = tg[0];
        end
        wb_ex(ptag, 32'hB00 + 32'd33, 0, 0);
        tick();
        clr_wb();
        wait_count(0, 10, "stream_drain");

        // Asynchronous reset mid-operation
        do_alloc(5'd9, 0, 0, 0, tg[0]);
        do_alloc(5'd9, 0, 0, 0, tg[1]);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_count", bus.count_o, 0);
        chk("arst_ready", bus.alloc_ready_o, 0);
        chk("arst_tail", bus.alloc_tag_o, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tl = 0;
        tick();
        chk("arst_resume", bus.alloc_ready_o, 1);

        chk("rfq_drained", 64'(rfq.size()), 0);
        chk("flq_drained", 64'(flq.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/reorder_buffer_p.md
# reorder_buffer_p

Parametrised in-order retirement queue for the out-of-order core, sitting between dispatch (allocation), the EX/LSB result buses (writeback), and the register file/store buffer (commit). It replaces the fixed 32-entry buffer with configurable depth and widths, count-based full/empty, a store-commit handshake, branch-mispredict flush with redirect PC, and optional operand-forwarding query ports.

## Interface
- DEPTH, 32, entry count; power of 2, ≥4; TAG_W = $clog2(DEPTH)
- DATA_W, 32, result width
- ADDR_W, 32, PC width
- REG_W, 5, architectural register index width
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes all state
- alloc_valid_i  in  1  dispatch requests an entry
- alloc_ready_o  out  1  = !full && !flush_o
- alloc_tag_o  out  TAG_W  tag granted (= tail), combinational
- alloc_rd_i  in  REG_W  destination register
- alloc_is_store_i / alloc_is_branch_i / alloc_pred_taken_i  in  1 each  entry class, predicted direction
- ex_valid_i, ex_tag_i, ex_data_i, ex_taken_i, ex_npc_i  in  1/TAG_W/DATA_W/1/ADDR_W  EX writeback; ex_npc_i = correct next PC
- lsb_valid_i, lsb_tag_i, lsb_data_i  in  1/TAG_W/DATA_W  load/store-address writeback
- st_commit_valid_o, st_commit_tag_o  out  1/TAG_W  head store may write memory
- st_commit_ack_i  in  1  store buffer accepted
- rf_we_o, rf_rd_o, rf_data_o, rf_tag_o  out  1/REG_W/DATA_W/TAG_W  register commit
- flush_o, flush_pc_o  out  1/ADDR_W  mispredict flush pulse, redirect PC
- count_o  out  TAG_W+1  occupancy
- q0_tag_i, q1_tag_i  in  TAG_W; q0_ready_o, q1_ready_o  out 1; q0_data_o, q1_data_o  out DATA_W  (only with ROB_FWD_EN)

## Operation
- Entry fields: busy, done, rd, data, is_store, is_branch, pred, taken, npc. head/tail TAG_W bits, wrap naturally; count separate; full = count==DEPTH, empty = count==0.
- Allocate on alloc_valid_i && alloc_ready_o && rdy: write entry at tail, busy=1, done=0, tail++.
- Writeback (EX and LSB, both same cycle allowed, distinct tags): sets data, done=1 (EX also taken, npc). Writeback to non-busy tag ignored.
- Commit (head, !empty, done): non-store retires: rf_we_o=1 if rd≠0, head++. If is_branch && taken≠pred: retire plus flush — all entries cleared, head=tail=count=0, flush_o=1, flush_pc_o=npc.
- Store at head with done: st_commit_valid_o held until st_commit_ack_i; retire on ack edge. No flush on stores.
- Alloc and retire same cycle: count unchanged. Mispredicting commit cycle: same-cycle alloc and writebacks dropped.
- rdy low: state frozen, rf_we_o=flush_o=0, st_commit_valid_o held.
- Reset: all entries cleared, head=tail=count=0, every output 0.

## Timing
- Writeback at edge E → head eligible cycle after E → retire at edge E+1; rf_we_o/flush_o registered, high exactly one cycle after retire edge.
- flush_o cycle: alloc_ready_o=0; allocation resumes next cycle at tag 0.
- Store: ack sampled at edge; st_commit_valid_o drops the cycle after ack.
- Reset mid-operation (async): outputs 0 immediately, buffer empty.

## Configuration
- ROB_FWD_EN defined: q0/q1 ports present; q_ready_o = busy && done, or same-cycle EX/LSB writeback matching tag (writeback data bypassed, EX priority). Undefined: ports and bypass logic absent.

## Structure
- Shared config header: ROB depth default, TAG width macro, NotJump/Jump encoding, entry-class flags.
- One sub-module natural: rob_qport (single tag lookup + writeback bypass), instantiated twice under ROB_FWD_EN.

## Test plan
- Reset, allocate 32 (DEPTH=32) → count_o=32, alloc_ready_o=0; writeback tags 0..31 in reverse → 32 in-order rf_we_o pulses, tags 0..31.
- Alloc rd=0 entry, writeback → retires, rf_we_o=0, count decrements.
- Branch pred=0, ex_taken=1, ex_npc=0x1000, 3 younger entries → flush_o one cycle, flush_pc_o=0x1000, count_o=0, next alloc_tag_o=0.
- Store at head, lsb writeback, ack delayed 3 cycles → st_commit_valid_o high 3 cycles, retire on ack, next head commits after.
- Wrap: DEPTH=4, 10 alloc/retire rounds with alloc+retire same cycle → count stable, tags wrap 3→0.
- ROB_FWD_EN: q0_tag=5 with ex writeback tag 5 data 0xDEAD same cycle → q0_ready_o=1, q0_data_o=0xDEAD.
